gf180mcu_fd_sc_mcu7t5v0__tie_seq: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__tie_seq.sv | 110 +++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__tie_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_seq.sv
// Sequenced WIDTH-bit tie cell. Holds SAFE_VAL through reset and a settle window, then drives
// the shadow tie value. The shadow can be reloaded over valid/ready until a one-way lock.
module gf180mcu_fd_sc_mcu7t5v0__tie_seq #(
   parameter int unsigned     WIDTH      = 8,
   parameter logic [WIDTH-1:0] TIE_VAL   = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] SAFE_VAL  = {WIDTH{1'b0}},
   parameter int unsigned     SETTLE_CYC = 4
) (
   input  logic             CLK,
   input  logic             RN,
   inout  wire              VDD,
   inout  wire              VSS,
   input  logic             LD_VALID,
   output logic             LD_READY,
   input  logic [WIDTH-1:0] LD_DATA,
   input  logic             LD_LOCK,
   output logic [WIDTH-1:0] Z,
   output logic             READY,
   output logic             LOCKED
);

   localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYC - 1);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : gen_bad_settle
      $error("SETTLE_CYC must be in 1..255");
   end
   if (WIDTH < 1 || WIDTH > 64) begin : gen_bad_width
      $error("WIDTH must be in 1..64");
   end

   typedef enum logic [1:0] {StSettle, StActive, StLocked} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             ready_q, ready_d;
   logic             ld_ready_q, ld_ready_d;
   logic             locked_q, locked_d;

   // Power pins are connection-only.
   logic unused_pwr;
   assign unused_pwr = VDD ^ VSS;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q    <= StSettle;
         cnt_q      <= '0;
         shadow_q   <= TIE_VAL;
         z_q        <= SAFE_VAL;
         ready_q    <= 1'b0;
         ld_ready_q <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         z_q        <= z_d;
         ready_q    <= ready_d;
         ld_ready_q <= ld_ready_d;
         locked_q   <= locked_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      z_d        = z_q;
      ready_d    = ready_q;
      ld_ready_d = ld_ready_q;
      locked_d   = locked_q;
      unique case (state_q)
         StSettle: begin
            if (cnt_q == CntLast) begin
               state_d    = StActive;
               z_d        = shadow_q;
               ready_d    = 1'b1;
               ld_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StActive: begin
            // ld_ready_q is always high here; gating on it keeps the handshake explicit.
            if (LD_VALID && ld_ready_q) begin
               shadow_d = LD_DATA;
               z_d      = LD_DATA;
               if (LD_LOCK) begin
                  state_d    = StLocked;
                  ld_ready_d = 1'b0;
                  locked_d   = 1'b1;
               end
            end
         end
         StLocked: begin
         end
         default: begin
            state_d = StSettle;
         end
      endcase
   end

   assign Z        = z_q;
   assign READY    = ready_q;
   assign LD_READY = ld_ready_q;
   assign LOCKED   = locked_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__tie_seq.sv
// Directed bench for the sequenced tie cell: default instance plus a SETTLE_CYC=1 instance.
module tb_gf180mcu_fd_sc_mcu7t5v0__tie_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   wire vdd = 1'b1;
   wire vss = 1'b0;

   int checks   = 0;
   int failures = 0;

   // Instance A: defaults.
   logic       rn_a = 1'b0;
   logic       ld_valid_a = 1'b0;
   logic [7:0] ld_data_a = 8'h00;
   logic       ld_lock_a = 1'b0;
   logic       ld_ready_a, ready_a, locked_a;
   logic [7:0] z_a;

   gf180mcu_fd_sc_mcu7t5v0__tie_seq u_dut_a (
      .CLK      (clk),
      .RN       (rn_a),
      .VDD      (vdd),
      .VSS      (vss),
      .LD_VALID (ld_valid_a),
      .LD_READY (ld_ready_a),
      .LD_DATA  (ld_data_a),
      .LD_LOCK  (ld_lock_a),
      .Z        (z_a),
      .READY    (ready_a),
      .LOCKED   (locked_a)
   );

   // Instance B: one-cycle settle, distinct tie value.
   logic       rn_b = 1'b0;
   logic       ld_valid_b = 1'b1;
   logic [7:0] ld_data_b = 8'h3C;
   logic       ld_lock_b = 1'b1;
   logic       ld_ready_b, ready_b, locked_b;
   logic [7:0] z_b;

   gf180mcu_fd_sc_mcu7t5v0__tie_seq #(
      .WIDTH      (8),
      .TIE_VAL    (8'hA5),
      .SAFE_VAL   (8'h00),
      .SETTLE_CYC (1)
   ) u_dut_b (
      .CLK      (clk),
      .RN       (rn_b),
      .VDD      (vdd),
      .VSS      (vss),
      .LD_VALID (ld_valid_b),
      .LD_READY (ld_ready_b),
      .LD_DATA  (ld_data_b),
      .LD_LOCK  (ld_lock_b),
      .Z        (z_b),
      .READY    (ready_b),
      .LOCKED   (locked_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; sample and drive 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state of A.
      #12;
      check("a_rst_z", 64'(z_a), 64'h00);
      check("a_rst_ready", 64'(ready_a), 64'h0);
      check("a_rst_ld_ready", 64'(ld_ready_a), 64'h0);
      check("a_rst_locked", 64'(locked_a), 64'h0);

      // Release between edges, then settle window.
      rn_a = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("a_settle_z_e%0d", i), 64'(z_a), 64'h00);
         check($sformatf("a_settle_ready_e%0d", i), 64'(ready_a), 64'h0);
         check($sformatf("a_settle_ldr_e%0d", i), 64'(ld_ready_a), 64'h0);
      end
      step();
      check("a_rel_z", 64'(z_a), 64'hFF);
      check("a_rel_ready", 64'(ready_a), 64'h1);
      check("a_rel_ld_ready", 64'(ld_ready_a), 64'h1);
      check("a_rel_locked", 64'(locked_a), 64'h0);

      // Unlocked reloads, back to back.
      ld_valid_a = 1'b1; ld_data_a = 8'h5A; ld_lock_a = 1'b0;
      step();
      check("a_ld1_z", 64'(z_a), 64'h5A);
      check("a_ld1_locked", 64'(locked_a), 64'h0);
      check("a_ld1_ld_ready", 64'(ld_ready_a), 64'h1);
      ld_data_a = 8'hC3;
      step();
      check("a_ld2_z", 64'(z_a), 64'hC3);

      // Locking reload.
      ld_data_a = 8'h0F; ld_lock_a = 1'b1;
      step();
      check("a_lock_z", 64'(z_a), 64'h0F);
      check("a_lock_locked", 64'(locked_a), 64'h1);
      check("a_lock_ld_ready", 64'(ld_ready_a), 64'h0);
      check("a_lock_ready", 64'(ready_a), 64'h1);

      // Reloads refused once locked.
      ld_data_a = 8'hAA; ld_lock_a = 1'b0;
      step();
      check("a_refuse1_z", 64'(z_a), 64'h0F);
      step();
      check("a_refuse2_z", 64'(z_a), 64'h0F);
      check("a_refuse2_locked", 64'(locked_a), 64'h1);
      ld_valid_a = 1'b0;

      // Async reset between edges.
      rn_a = 1'b0;
      #2;
      check("a_async_z", 64'(z_a), 64'h00);
      check("a_async_ready", 64'(ready_a), 64'h0);
      check("a_async_locked", 64'(locked_a), 64'h0);
      check("a_async_ld_ready", 64'(ld_ready_a), 64'h0);
      rn_a = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("a_resettle_z_e%0d", i), 64'(z_a), 64'h00);
      end
      step();
      check("a_rerel_z", 64'(z_a), 64'hFF);
      check("a_rerel_ready", 64'(ready_a), 64'h1);
      check("a_rerel_locked", 64'(locked_a), 64'h0);

      // Instance B: LD_VALID held high with lock through reset and release.
      check("b_rst_z", 64'(z_b), 64'h00);
      rn_b = 1'b1;
      #2;
      check("b_pre_edge_ready", 64'(ready_b), 64'h0);
      step();
      check("b_rel_z", 64'(z_b), 64'hA5);
      check("b_rel_ready", 64'(ready_b), 64'h1);
      check("b_rel_ld_ready", 64'(ld_ready_b), 64'h1);
      check("b_rel_locked", 64'(locked_b), 64'h0);
      step();
      check("b_ld_z", 64'(z_b), 64'h3C);
      check("b_ld_locked", 64'(locked_b), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
